// File: rtl/sample_ram_sched_pkg.sv
// Shared definitions for the capture sample RAM scheduler and the zoom control FSM.
package sample_ram_sched_pkg;

    // Zoom codes as produced by the zoom control FSM (horizontal magnification).
    localparam logic [1:0] ZOOM_X1 = 2'd0;
    localparam logic [1:0] ZOOM_X2 = 2'd1;
    localparam logic [1:0] ZOOM_X4 = 2'd2;
    localparam logic [1:0] ZOOM_X8 = 2'd3;

    // Default geometry of the analyzer.
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_CH       = 4;
    localparam int DEF_H_ACTIVE = 640;

    // Capture sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sample_ram_sched_pix_addr_gen.sv
// Display-side address generator: pixel counter, per-line zoom latch and
// shift-based mapping from screen column to sample RAM address.
module pix_addr_gen
    import sample_ram_sched_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [1:0]        i_zoom,
    input  logic              i_line_start,
    input  logic              i_pix_req,
    output logic [ADDR_W-1:0] o_rd_addr
);

    localparam int PIX_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(H_ACTIVE - 1);

    logic [PIX_W-1:0]        r_pix;
    logic [1:0]              r_zoom;
    logic [PIX_W-1:0]        w_pix;
    logic [1:0]              w_zoom;
    logic [PIX_W-1:0]        w_shift;
    logic [PIX_W+ADDR_W-1:0] w_ext;

    // A line start in the same cycle as a request must already use pixel 0
    // and the new zoom, so both are bypassed around their registers here.
    always_comb begin
        w_pix   = i_line_start ? '0 : r_pix;
        w_zoom  = i_line_start ? i_zoom : r_zoom;
        w_shift = w_pix >> w_zoom;
        w_ext   = {{ADDR_W{1'b0}}, w_shift};
    end

    assign o_rd_addr = w_ext[ADDR_W-1:0];

    // Pixel counter restarts on line start and saturates on the last active column.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pix  <= '0;
            r_zoom <= ZOOM_X1;
        end else begin
            if (i_line_start) begin
                r_zoom <= i_zoom;
            end
            if (i_pix_req && (w_pix != PIX_LAST)) begin
                r_pix <= w_pix + PIX_W'(1);
            end else if (i_line_start) begin
                r_pix <= '0;
            end
        end
    end

endmodule

// File: rtl/sample_ram_sched.sv
// Single-port capture sample RAM owner: sequences one capture run and
// arbitrates the RAM between the capture writer and the display reader.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | no run armed; capture samples are refused
// ST_CAPTURE | writing accepted samples from address 0 up to depth-1
// ST_DONE    | RAM full; waits for the next arm to start a fresh run
module sample_ram_sched
    import sample_ram_sched_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CH       = DEF_CH,
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [1:0]        i_zoom,
    input  logic              i_arm,
    input  logic              i_cap_valid,
    input  logic [CH-1:0]     i_cap_data,
    output logic              o_cap_ready,
    output logic              o_capturing,
    output logic              o_capture_done,
    input  logic              i_line_start,
    input  logic              i_pix_req,
    output logic [CH-1:0]     o_pix_data,
    output logic              o_pix_valid,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [CH-1:0]     o_ram_wdata,
    input  logic [CH-1:0]     i_ram_rdata
);

    localparam logic [ADDR_W-1:0] WPTR_LAST = {ADDR_W{1'b1}};

    cap_state_t        r_state;
    cap_state_t        w_state_nxt;
    logic              w_wptr_clr;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_pix_valid;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_wr;

    pix_addr_gen #(
        .ADDR_W   (ADDR_W),
        .H_ACTIVE (H_ACTIVE)
    ) u_pix_addr_gen (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_zoom       (i_zoom),
        .i_line_start (i_line_start),
        .i_pix_req    (i_pix_req),
        .o_rd_addr    (w_rd_addr)
    );

    // Display reads win every collision; the capture sample stays upstream.
    assign o_cap_ready    = (r_state == ST_CAPTURE) && !i_pix_req;
    assign w_wr           = o_cap_ready && i_cap_valid;
    assign o_capturing    = (r_state == ST_CAPTURE);
    assign o_capture_done = (r_state == ST_DONE);

    // Next-state logic; arming restarts the write pointer at address 0.
    always_comb begin
        w_state_nxt = r_state;
        w_wptr_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_arm) begin
                    w_state_nxt = ST_CAPTURE;
                    w_wptr_clr  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (w_wr && (r_wptr == WPTR_LAST)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_arm) begin
                    w_state_nxt = ST_CAPTURE;
                    w_wptr_clr  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write pointer: cleared on arm, advanced on each accepted sample.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr <= '0;
        end else if (w_wptr_clr) begin
            r_wptr <= '0;
        end else if (w_wr) begin
            r_wptr <= r_wptr + ADDR_W'(1);
        end
    end

    // RAM port mux; idle cycles keep the previous address on the bus.
    always_comb begin
        w_ram_addr = r_last_addr;
        if (i_pix_req) begin
            w_ram_addr = w_rd_addr;
        end else if (w_wr) begin
            w_ram_addr = r_wptr;
        end
    end

    assign o_ram_addr  = w_ram_addr;
    assign o_ram_we    = w_wr;
    assign o_ram_wdata = w_wr ? i_cap_data : '0;

    // Remember the last driven address so idle cycles do not toggle the bus.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_last_addr <= '0;
        end else begin
            r_last_addr <= w_ram_addr;
        end
    end

    // Read return flag; the RAM output register is the data stage itself,
    // so the data is only masked to zero outside the valid cycle.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= i_pix_req;
        end
    end

    assign o_pix_valid = r_pix_valid;
    assign o_pix_data  = r_pix_valid ? i_ram_rdata : '0;

endmodule
